// File: rtl/ccip_rd_arbiter_pkg.sv
// Shared definitions for the pipearch CCI-P glue: instance tag placement in
// mdata and the cl_len to line-count conversion.
package pipearch_common;

  // Instance ID lives in the top two bits of mdata on both c0 Tx and c0 Rx.
  localparam int INST_TAG_W    = 2;
  localparam int MDATA_TAG_MSB = 15;

  // Position of cl_len inside t_ccip_c0_ReqMemHdr.
  localparam int C0_REQ_CL_LEN_LSB = 68;

  typedef logic [INST_TAG_W-1:0] t_inst_id;

  // Number of cache lines a request covers: cl_len + 1.
  function automatic logic [2:0] len_lines(input logic [1:0] cl_len);
    return {1'b0, cl_len} + 3'd1;
  endfunction

endpackage

// File: rtl/ccip_rd_arbiter_rr_arbiter.sv
// Generic N-way round-robin arbiter. The grant is combinational and starts
// searching at ptr; ptr moves to one past the winner after each grant.
module rr_arbiter #(
  parameter int N = 2,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  grant,
  output logic          grant_valid,
  output logic [PW-1:0] grant_id
);

  logic [PW-1:0] ptr;
  int            idx;

  // Pick the first requester at or after ptr, wrapping around.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    grant_id    = '0;
    idx         = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!grant_valid && req[PW'(idx)]) begin
        grant[PW'(idx)] = 1'b1;
        grant_valid     = 1'b1;
        grant_id        = PW'(idx);
      end
    end
  end

  // Advance the pointer past the winner; hold when nothing was granted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (grant_valid) begin
      ptr <= (int'(grant_id) == N - 1) ? '0 : grant_id + 1'b1;
    end
  end

endmodule

// File: rtl/ccip_rd_arbiter.sv
// Shares the CCI-P c0 read-request channel among NUM_INSTANCES requesters,
// limits each requester's in-flight lines, tags mdata[15:14] with the
// requester ID and routes c0 read responses back by that tag.
//
// Request handshake: a requester holds req_valid and req_hdr stable until it
// sees req_ready; the request is consumed in the cycle where both are high.
// req_ready is one-hot and may depend combinationally on req_valid.
// Responses have no backpressure: rsp_valid is a one-cycle strobe.
module ccip_rd_arbiter
  import pipearch_common::*;
#(
  parameter int NUM_INSTANCES   = 2,
  parameter int MAX_OUTSTANDING = 64,
  parameter int REQ_HDR_W       = 74,
  parameter int RSP_HDR_W       = 28
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [NUM_INSTANCES-1:0]           req_valid,
  input  logic [NUM_INSTANCES*REQ_HDR_W-1:0] req_hdr,
  output logic [NUM_INSTANCES-1:0]           req_ready,
  input  logic                               c0_tx_almfull,
  output logic                               c0_tx_valid,
  output logic [REQ_HDR_W-1:0]               c0_tx_hdr,
  input  logic                               c0_rx_valid,
  input  logic [RSP_HDR_W-1:0]               c0_rx_hdr,
  input  logic [511:0]                       c0_rx_data,
  output logic [NUM_INSTANCES-1:0]           rsp_valid,
  output logic [RSP_HDR_W-1:0]               rsp_hdr,
  output logic [511:0]                       rsp_data,
  output logic                               idle,
  output logic [1:0]                         err_sticky
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = (NUM_INSTANCES > 1) ? $clog2(NUM_INSTANCES) : 1;

  logic [REQ_HDR_W-1:0]     hdr_in   [NUM_INSTANCES];
  logic [2:0]               len      [NUM_INSTANCES];
  logic [CW-1:0]            cnt      [NUM_INSTANCES];
  logic [CW-1:0]            cnt_next [NUM_INSTANCES];
  logic [NUM_INSTANCES-1:0] eligible;
  logic [NUM_INSTANCES-1:0] grant;
  logic [NUM_INSTANCES-1:0] underflow;
  logic                     grant_valid;
  logic [PW-1:0]            grant_id;
  logic [REQ_HDR_W-1:0]     tagged_hdr;
  logic [RSP_HDR_W-1:0]     rx_hdr_clr;
  t_inst_id                 rx_tag;
  logic                     bad_tag;
  logic                     idle_next;
  logic                     rsp_hit;
  int                       cnt_sum;

  assign rx_tag  = c0_rx_hdr[MDATA_TAG_MSB -: INST_TAG_W];
  assign bad_tag = int'(rx_tag) >= NUM_INSTANCES;

  // Unpack headers and decide who may compete: valid, no almfull, and the
  // whole request fits under the credit limit. Nothing is eligible in reset.
  always_comb begin
    for (int i = 0; i < NUM_INSTANCES; i++) begin
      hdr_in[i]   = req_hdr[i*REQ_HDR_W +: REQ_HDR_W];
      len[i]      = len_lines(hdr_in[i][C0_REQ_CL_LEN_LSB+1:C0_REQ_CL_LEN_LSB]);
      eligible[i] = reset_n && req_valid[i] && !c0_tx_almfull &&
                    (int'(cnt[i]) + int'(len[i]) <= MAX_OUTSTANDING);
    end
  end

  rr_arbiter #(.N(NUM_INSTANCES)) u_rr (
    .clk         (clk),
    .reset_n     (reset_n),
    .req         (eligible),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  assign req_ready = grant;

  // Select the winning header and overwrite its mdata tag with the winner ID.
  always_comb begin
    tagged_hdr = '0;
    for (int i = 0; i < NUM_INSTANCES; i++) begin
      if (grant[i]) tagged_hdr = hdr_in[i];
    end
    tagged_hdr[MDATA_TAG_MSB -: INST_TAG_W] = t_inst_id'(grant_id);
  end

  // Register the granted request; the header holds when nothing is granted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      c0_tx_valid <= 1'b0;
      c0_tx_hdr   <= '0;
    end else begin
      c0_tx_valid <= grant_valid;
      if (grant_valid) c0_tx_hdr <= tagged_hdr;
    end
  end

  // Next credit count: add the granted length, retire one line per tagged
  // response. A response against an empty counter is flagged, not counted.
  always_comb begin
    rsp_hit   = 1'b0;
    cnt_sum   = 0;
    idle_next = !grant_valid;
    for (int i = 0; i < NUM_INSTANCES; i++) begin
      rsp_hit      = c0_rx_valid && !bad_tag && (int'(rx_tag) == i);
      cnt_sum      = int'(cnt[i]) + (grant[i] ? int'(len[i]) : 0);
      underflow[i] = rsp_hit && (cnt[i] == '0);
      if (rsp_hit && (cnt[i] != '0)) cnt_sum = cnt_sum - 1;
      cnt_next[i]  = CW'(cnt_sum);
      if (cnt_next[i] != '0) idle_next = 1'b0;
    end
  end

  // Outstanding-line counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_INSTANCES; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_INSTANCES; i++) cnt[i] <= cnt_next[i];
    end
  end

  // Response header with the instance tag stripped.
  always_comb begin
    rx_hdr_clr = c0_rx_hdr;
    rx_hdr_clr[MDATA_TAG_MSB -: INST_TAG_W] = '0;
  end

  // Route responses by tag, track sticky errors and the idle indication.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid  <= '0;
      rsp_hdr    <= '0;
      rsp_data   <= '0;
      idle       <= 1'b0;
      err_sticky <= '0;
    end else begin
      rsp_valid <= '0;
      if (c0_rx_valid) begin
        rsp_hdr  <= rx_hdr_clr;
        rsp_data <= c0_rx_data;
        if (!bad_tag) rsp_valid <= NUM_INSTANCES'(1) << rx_tag;
      end
      err_sticky[0] <= err_sticky[0] | (c0_rx_valid & bad_tag);
      err_sticky[1] <= err_sticky[1] | (|underflow);
      idle          <= idle_next;
    end
  end

endmodule

// File: tb/tb_ccip_rd_arbiter.sv
// Self-checking bench for ccip_rd_arbiter (2 instances, 4-line credit limit).
// A behavioural model tracks per-instance credits, the round-robin start and
// the sticky errors; expected outputs are derived from it each cycle.
module tb_ccip_rd_arbiter;
  localparam int N   = 2;
  localparam int MAX = 4;
  localparam int RQW = 74;
  localparam int RSW = 28;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [N-1:0]     req_valid = '0;
  logic [N*RQW-1:0] req_hdr = '0;
  logic [N-1:0]     req_ready;
  logic             c0_tx_almfull = 1'b0;
  logic             c0_tx_valid;
  logic [RQW-1:0]   c0_tx_hdr;
  logic             c0_rx_valid = 1'b0;
  logic [RSW-1:0]   c0_rx_hdr = '0;
  logic [511:0]     c0_rx_data = '0;
  logic [N-1:0]     rsp_valid;
  logic [RSW-1:0]   rsp_hdr;
  logic [511:0]     rsp_data;
  logic             idle;
  logic [1:0]       err_sticky;

  int n_cmp = 0;
  int n_fail = 0;

  // Behavioural model state and expected registered outputs.
  int             m_cnt [N];
  int             m_ptr;
  logic [1:0]     m_err;
  logic           exp_tx_valid;
  logic [RQW-1:0] exp_tx_hdr;
  logic [N-1:0]   exp_rsp_valid;
  logic [RSW-1:0] exp_rsp_hdr;
  logic [511:0]   exp_rsp_data;
  logic           exp_idle;

  ccip_rd_arbiter #(
    .NUM_INSTANCES(N), .MAX_OUTSTANDING(MAX), .REQ_HDR_W(RQW), .RSP_HDR_W(RSW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_hdr(req_hdr),
    .req_ready(req_ready), .c0_tx_almfull(c0_tx_almfull), .c0_tx_valid(c0_tx_valid),
    .c0_tx_hdr(c0_tx_hdr), .c0_rx_valid(c0_rx_valid), .c0_rx_hdr(c0_rx_hdr),
    .c0_rx_data(c0_rx_data), .rsp_valid(rsp_valid), .rsp_hdr(rsp_hdr),
    .rsp_data(rsp_data), .idle(idle), .err_sticky(err_sticky)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within 1 ms");
    $fatal(1);
  end

  // ---------------- model ----------------
  task automatic model_reset();
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    m_ptr = 0; m_err = 2'b00;
    exp_tx_valid = 1'b0; exp_tx_hdr = '0; exp_rsp_valid = '0;
    exp_rsp_hdr = '0; exp_rsp_data = '0; exp_idle = 1'b0;
  endtask

  function automatic int hdr_len(input int i);
    logic [RQW-1:0] h;
    h = req_hdr[i*RQW +: RQW];
    return int'(h[69:68]) + 1;
  endfunction

  // Round-robin search from m_ptr among requesters that fit their credit.
  function automatic int model_grant();
    for (int k = 0; k < N; k++) begin
      int i = (m_ptr + k) % N;
      if (req_valid[i] && !c0_tx_almfull && (m_cnt[i] + hdr_len(i) <= MAX)) return i;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] grant_vec(input int g);
    return (g < 0) ? '0 : N'(1 << g);
  endfunction

  // ---------------- drivers ----------------
  task automatic set_req(input int i, input logic v, input logic [1:0] cl, input logic [15:0] md);
    logic [41:0] a;
    a = 42'({$urandom, $urandom});
    req_valid[i] = v;
    req_hdr[i*RQW +: RQW] = {2'b00, 2'b00, cl, 4'h0, 6'h00, a, md};
  endtask

  task automatic send_rsp(input logic [1:0] tag, input logic [13:0] low);
    c0_rx_valid = 1'b1;
    c0_rx_hdr   = {12'($urandom), tag, low};
    for (int w = 0; w < 16; w++) c0_rx_data[w*32 +: 32] = $urandom;
  endtask

  // Advance the model over one rising edge, then step the clock.
  task automatic tick();
    int g, t;
    logic [RQW-1:0] h;
    g = model_grant();
    exp_rsp_valid = '0;
    if (c0_rx_valid) begin
      t = int'(c0_rx_hdr[15:14]);
      exp_rsp_hdr = c0_rx_hdr; exp_rsp_hdr[15:14] = 2'b00;
      exp_rsp_data = c0_rx_data;
      if (t >= N) m_err[0] = 1'b1;
      else begin
        exp_rsp_valid = N'(1 << t);
        if (m_cnt[t] == 0) m_err[1] = 1'b1; else m_cnt[t] = m_cnt[t] - 1;
      end
    end
    if (g >= 0) begin
      h = req_hdr[g*RQW +: RQW]; h[15:14] = 2'(g);
      exp_tx_hdr = h; exp_tx_valid = 1'b1;
      m_cnt[g] = m_cnt[g] + hdr_len(g);
      m_ptr = (g + 1) % N;
    end else begin
      exp_tx_valid = 1'b0;
    end
    exp_idle = !exp_tx_valid;
    for (int i = 0; i < N; i++) if (m_cnt[i] != 0) exp_idle = 1'b0;
    @(posedge clk); #1;
    c0_rx_valid = 1'b0;
  endtask

  // Return all outstanding credits with one response per cycle.
  task automatic drain();
    int t;
    req_valid = '0;
    while (m_cnt[0] != 0 || m_cnt[1] != 0) begin
      t = (m_cnt[0] != 0) ? 0 : 1;
      send_rsp(2'(t), 14'($urandom));
      tick();
    end
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    set_req(0, 1'b1, 2'd0, 16'h1111); set_req(1, 1'b1, 2'd0, 16'h2222);
    repeat (2) @(posedge clk); #1;
    n_cmp++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL rst_ready act=%b exp=00", req_ready); end
    n_cmp++; if (c0_tx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_tx_valid act=%b exp=0", c0_tx_valid); end
    n_cmp++; if (c0_tx_hdr !== '0) begin n_fail++; $display("FAIL rst_tx_hdr act=%h exp=0", c0_tx_hdr); end
    n_cmp++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL rst_rsp_valid act=%b exp=00", rsp_valid); end
    n_cmp++; if (idle !== 1'b0) begin n_fail++; $display("FAIL rst_idle act=%b exp=0", idle); end
    n_cmp++; if (err_sticky !== 2'b00) begin n_fail++; $display("FAIL rst_err act=%b exp=00", err_sticky); end
    req_valid = '0;
    model_reset();
    reset_n = 1'b1;
    tick();
    n_cmp++; if (idle !== 1'b1) begin n_fail++; $display("FAIL rst_idle_after act=%b exp=1", idle); end
    n_cmp++; if (c0_tx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_tx_after act=%b exp=0", c0_tx_valid); end
  endtask

  task automatic test_single();
    set_req(1, 1'b1, 2'd0, 16'h3ABC); #1;
    n_cmp++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL single_ready act=%b exp=10", req_ready); end
    tick();
    req_valid = '0;
    n_cmp++; if (c0_tx_valid !== 1'b1) begin n_fail++; $display("FAIL single_tx_valid act=%b exp=1", c0_tx_valid); end
    n_cmp++; if (c0_tx_hdr[15:0] !== 16'h7ABC) begin n_fail++; $display("FAIL single_mdata act=%h exp=7abc", c0_tx_hdr[15:0]); end
    n_cmp++; if (c0_tx_hdr !== exp_tx_hdr) begin n_fail++; $display("FAIL single_tx_hdr act=%h exp=%h", c0_tx_hdr, exp_tx_hdr); end
    n_cmp++; if (idle !== 1'b0) begin n_fail++; $display("FAIL single_busy act=%b exp=0", idle); end
    send_rsp(2'd1, 14'h3ABC);
    tick();
    n_cmp++; if (rsp_valid !== 2'b10) begin n_fail++; $display("FAIL single_rsp_valid act=%b exp=10", rsp_valid); end
    n_cmp++; if (rsp_hdr[15:0] !== 16'h3ABC) begin n_fail++; $display("FAIL single_rsp_mdata act=%h exp=3abc", rsp_hdr[15:0]); end
    n_cmp++; if (rsp_hdr !== exp_rsp_hdr) begin n_fail++; $display("FAIL single_rsp_hdr act=%h exp=%h", rsp_hdr, exp_rsp_hdr); end
    n_cmp++; if (rsp_data !== exp_rsp_data) begin n_fail++; $display("FAIL single_rsp_data mismatch on data word0 act=%h exp=%h", rsp_data[31:0], exp_rsp_data[31:0]); end
    n_cmp++; if (idle !== 1'b1) begin n_fail++; $display("FAIL single_idle act=%b exp=1", idle); end
  endtask

  task automatic test_fairness();
    int n0 = 0, n1 = 0;
    logic [1:0] e;
    for (int k = 0; k < 8; k++) begin
      set_req(0, 1'b1, 2'd0, 16'($urandom)); set_req(1, 1'b1, 2'd0, 16'($urandom)); #1;
      e = (k % 2 == 0) ? 2'b01 : 2'b10;
      n_cmp++; if (req_ready !== e) begin n_fail++; $display("FAIL fair_ready[%0d] act=%b exp=%b", k, req_ready, e); end
      if (req_ready[0]) n0++;
      if (req_ready[1]) n1++;
      tick();
      n_cmp++; if (c0_tx_hdr !== exp_tx_hdr) begin n_fail++; $display("FAIL fair_tx_hdr[%0d] act=%h exp=%h", k, c0_tx_hdr, exp_tx_hdr); end
    end
    n_cmp++; if (n0 != 4 || n1 != 4) begin n_fail++; $display("FAIL fair_count act=%0d/%0d exp=4/4", n0, n1); end
    drain();
    n_cmp++; if (idle !== 1'b1) begin n_fail++; $display("FAIL fair_drain_idle act=%b exp=1", idle); end
  endtask

  task automatic test_credit();
    req_valid = '0;
    for (int k = 0; k < 4; k++) begin
      set_req(0, 1'b1, 2'd0, 16'($urandom)); #1;
      n_cmp++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL credit_fill[%0d] act=%b exp=01", k, req_ready); end
      tick();
    end
    #1;
    n_cmp++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL credit_block act=%b exp=00", req_ready); end
    set_req(1, 1'b1, 2'd0, 16'($urandom)); #1;
    n_cmp++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL credit_other act=%b exp=10", req_ready); end
    tick();
    set_req(1, 1'b0, 2'd0, 16'h0);
    send_rsp(2'd0, 14'($urandom)); #1;
    n_cmp++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL credit_same_cycle act=%b exp=00", req_ready); end
    tick();
    n_cmp++; if (rsp_valid !== 2'b01) begin n_fail++; $display("FAIL credit_rsp act=%b exp=01", rsp_valid); end
    #1;
    n_cmp++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL credit_return act=%b exp=01", req_ready); end
    drain();
    set_req(0, 1'b1, 2'd0, 16'($urandom)); #1;
    tick();
    set_req(0, 1'b1, 2'd3, 16'($urandom)); #1;
    n_cmp++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL credit_len4_hold act=%b exp=00", req_ready); end
    send_rsp(2'd0, 14'($urandom));
    tick();
    #1;
    n_cmp++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL credit_len4_go act=%b exp=01", req_ready); end
    tick();
    n_cmp++; if (c0_tx_hdr !== exp_tx_hdr) begin n_fail++; $display("FAIL credit_len4_hdr act=%h exp=%h", c0_tx_hdr, exp_tx_hdr); end
    drain();
  endtask

  task automatic test_almfull();
    logic [1:0] e;
    set_req(0, 1'b1, 2'd0, 16'($urandom)); set_req(1, 1'b1, 2'd0, 16'($urandom)); #1;
    tick();
    c0_tx_almfull = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_cmp++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL almfull_ready[%0d] act=%b exp=00", k, req_ready); end
      n_cmp++; if (c0_tx_valid !== (k == 0)) begin n_fail++; $display("FAIL almfull_tx_valid[%0d] act=%b exp=%b", k, c0_tx_valid, (k == 0)); end
      tick();
    end
    c0_tx_almfull = 1'b0; #1;
    e = grant_vec(model_grant());
    n_cmp++; if (req_ready !== e || req_ready == 2'b00) begin n_fail++; $display("FAIL almfull_resume act=%b exp=%b", req_ready, e); end
    tick();
    n_cmp++; if (c0_tx_valid !== 1'b1) begin n_fail++; $display("FAIL almfull_resume_tx act=%b exp=1", c0_tx_valid); end
    drain();
  endtask

  task automatic test_random();
    int g, t;
    logic [1:0] cl;
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < N; i++) begin
        cl = ($urandom_range(0, 2) == 2) ? 2'd3 : 2'($urandom_range(0, 1));
        set_req(i, ($urandom_range(0, 2) != 0), cl, 16'($urandom));
      end
      c0_tx_almfull = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 1) == 1 && (m_cnt[0] != 0 || m_cnt[1] != 0)) begin
        t = $urandom_range(0, 1);
        if (m_cnt[t] == 0) t = 1 - t;
        send_rsp(2'(t), 14'($urandom));
      end
      #1;
      g = model_grant();
      n_cmp++; if (req_ready !== grant_vec(g)) begin n_fail++; $display("FAIL rnd_ready[%0d] act=%b exp=%b", k, req_ready, grant_vec(g)); end
      tick();
      n_cmp++; if (c0_tx_valid !== exp_tx_valid) begin n_fail++; $display("FAIL rnd_tx_valid[%0d] act=%b exp=%b", k, c0_tx_valid, exp_tx_valid); end
      if (exp_tx_valid) begin
        n_cmp++; if (c0_tx_hdr !== exp_tx_hdr) begin n_fail++; $display("FAIL rnd_tx_hdr[%0d] act=%h exp=%h", k, c0_tx_hdr, exp_tx_hdr); end
      end
      n_cmp++; if (rsp_valid !== exp_rsp_valid) begin n_fail++; $display("FAIL rnd_rsp_valid[%0d] act=%b exp=%b", k, rsp_valid, exp_rsp_valid); end
      if (exp_rsp_valid != '0) begin
        n_cmp++; if (rsp_hdr !== exp_rsp_hdr || rsp_data !== exp_rsp_data) begin n_fail++; $display("FAIL rnd_rsp_payload[%0d] hdr act=%h exp=%h", k, rsp_hdr, exp_rsp_hdr); end
      end
      n_cmp++; if (idle !== exp_idle) begin n_fail++; $display("FAIL rnd_idle[%0d] act=%b exp=%b", k, idle, exp_idle); end
      n_cmp++; if (err_sticky !== m_err) begin n_fail++; $display("FAIL rnd_err[%0d] act=%b exp=%b", k, err_sticky, m_err); end
    end
    c0_tx_almfull = 1'b0;
    drain();
  endtask

  task automatic test_simul_and_errors();
    req_valid = '0;
    set_req(0, 1'b1, 2'd0, 16'($urandom)); #1;
    tick(); tick();
    set_req(0, 1'b1, 2'd1, 16'($urandom));
    send_rsp(2'd0, 14'($urandom)); #1;
    n_cmp++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL simul_grant act=%b exp=01", req_ready); end
    tick();
    n_cmp++; if (rsp_valid !== 2'b01) begin n_fail++; $display("FAIL simul_rsp act=%b exp=01", rsp_valid); end
    n_cmp++; if (c0_tx_hdr !== exp_tx_hdr) begin n_fail++; $display("FAIL simul_tx_hdr act=%h exp=%h", c0_tx_hdr, exp_tx_hdr); end
    set_req(0, 1'b1, 2'd1, 16'($urandom)); #1;
    n_cmp++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL simul_cnt3_len2 act=%b exp=00", req_ready); end
    set_req(0, 1'b1, 2'd0, 16'($urandom)); #1;
    n_cmp++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL simul_cnt3_len1 act=%b exp=01", req_ready); end
    tick();
    drain();
    send_rsp(2'd3, 14'($urandom));
    tick();
    n_cmp++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL badtag_drop act=%b exp=00", rsp_valid); end
    n_cmp++; if (err_sticky !== 2'b01) begin n_fail++; $display("FAIL badtag_err act=%b exp=01", err_sticky); end
    send_rsp(2'd1, 14'($urandom));
    tick();
    n_cmp++; if (err_sticky !== 2'b11) begin n_fail++; $display("FAIL underflow_err act=%b exp=11", err_sticky); end
    n_cmp++; if (rsp_valid !== 2'b10) begin n_fail++; $display("FAIL underflow_rsp act=%b exp=10", rsp_valid); end
    n_cmp++; if (idle !== 1'b1) begin n_fail++; $display("FAIL underflow_idle act=%b exp=1", idle); end
    set_req(1, 1'b1, 2'd3, 16'($urandom)); #1;
    n_cmp++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL underflow_cnt_zero act=%b exp=10", req_ready); end
    tick();
    drain();
  endtask

  task automatic test_reset_mid();
    req_valid = '0;
    set_req(0, 1'b1, 2'd1, 16'($urandom)); #1;
    tick();
    set_req(0, 1'b1, 2'd0, 16'($urandom)); #1;
    tick();
    set_req(1, 1'b1, 2'd0, 16'($urandom));
    n_cmp++; if (c0_tx_valid !== 1'b1 || m_cnt[0] != 3) begin n_fail++; $display("FAIL rstmid_setup tx_valid act=%b exp=1", c0_tx_valid); end
    reset_n = 1'b0; #1;
    n_cmp++; if (c0_tx_valid !== 1'b0 || c0_tx_hdr !== '0) begin n_fail++; $display("FAIL rstmid_tx act=%b/%h exp=0/0", c0_tx_valid, c0_tx_hdr); end
    n_cmp++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL rstmid_ready act=%b exp=00", req_ready); end
    n_cmp++; if (idle !== 1'b0 || err_sticky !== 2'b00 || rsp_valid !== 2'b00) begin n_fail++; $display("FAIL rstmid_outs idle=%b err=%b rsp=%b exp=0/00/00", idle, err_sticky, rsp_valid); end
    model_reset();
    repeat (2) @(posedge clk); #1;
    reset_n = 1'b1; #1;
    n_cmp++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL rstmid_first_grant act=%b exp=01", req_ready); end
    tick();
    n_cmp++; if (c0_tx_valid !== 1'b1 || c0_tx_hdr !== exp_tx_hdr) begin n_fail++; $display("FAIL rstmid_tx_after act=%h exp=%h", c0_tx_hdr, exp_tx_hdr); end
    drain();
    n_cmp++; if (idle !== 1'b1) begin n_fail++; $display("FAIL rstmid_drain_idle act=%b exp=1", idle); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_fairness();
    test_credit();
    test_almfull();
    test_random();
    test_simul_and_errors();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ccip_rd_arbiter.md
Name: ccip_rd_arbiter

Overview:
- Shares the single CCI-P read-request channel (c0 Tx) among NUM_INSTANCES compute instances on one clock domain.
- Round-robin arbitration with per-instance outstanding-line credit limits.
- Tags mdata[15:14] with the instance ID and routes read responses (c0 Rx) back by that tag.
- Sits between the per-instance request ports and the platform c0 channel. Replaces ad-hoc arbitration in top-level glue.

Parameters:
- NUM_INSTANCES, 2, number of requesters; legal range 1..4 because the tag is 2 bits.
- MAX_OUTSTANDING, 64, maximum in-flight cache lines per instance.
- REQ_HDR_W, 74, width of t_ccip_c0_ReqMemHdr.
- RSP_HDR_W, 28, width of t_ccip_c0_RspMemHdr.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_INSTANCES  per-instance read request valid.
- req_hdr  in  NUM_INSTANCES*REQ_HDR_W  per-instance request header.
- req_ready  out  NUM_INSTANCES  one-hot grant; the request is consumed in the cycle where valid && ready.
- c0_tx_almfull  in  1  platform c0TxAlmFull.
- c0_tx_valid  out  1  request valid to the platform.
- c0_tx_hdr  out  REQ_HDR_W  tagged request header.
- c0_rx_valid  in  1  platform c0 rspValid (read responses only).
- c0_rx_hdr  in  RSP_HDR_W  response header.
- c0_rx_data  in  512  response data.
- rsp_valid  out  NUM_INSTANCES  per-instance response valid.
- rsp_hdr  out  RSP_HDR_W  response header with mdata[15:14] cleared; shared by all instances.
- rsp_data  out  512  response data; shared by all instances.
- idle  out  1  all outstanding counters are zero and no request is staged.
- err_sticky  out  2  bit0: response carried a bad tag; bit1: counter underflow.

Behaviour:
- Reset: while reset_n is low, all outputs are 0, all counters are 0, the RR pointer is 0 and err_sticky is 0. A reset asserted mid-operation discards in-flight state; responses arriving after reset deassertion for pre-reset requests are handled by the underflow rule.
- Eligibility of instance i: req_valid[i] && !c0_tx_almfull && (cnt[i] + len_i <= MAX_OUTSTANDING), where len_i = req_hdr[i].cl_len + 1 (1, 2 or 4 lines).
- Arbitration:
  - Combinational grant, round-robin starting from ptr.
  - req_ready is asserted only for the granted instance; at most one grant per cycle.
  - After a grant to instance g, ptr <= (g+1) mod NUM_INSTANCES. With no grant, ptr holds.
- Request output:
  - Registered, 1-cycle latency. In the cycle after a grant to g: c0_tx_valid=1 and c0_tx_hdr = the granted header with mdata[15:14]=g.
  - The requester's own mdata[15:14] is overwritten.
  - With no grant: c0_tx_valid=0 and c0_tx_hdr holds its previous value.
- Counters, width $clog2(MAX_OUTSTANDING+1):
  - Increment by len_g on grant.
  - Decrement by 1 on each c0_rx_valid tagged to that instance.
  - Grant and response to the same instance in the same cycle: cnt <= cnt + len_g - 1.
  - A response when cnt==0: cnt stays 0 and err_sticky[1] is set.
- Response routing:
  - Registered, 1-cycle latency: rsp_valid[t]=1 where t = c0_rx_hdr.mdata[15:14].
  - rsp_hdr and rsp_data are copied with mdata[15:14] zeroed.
  - If t >= NUM_INSTANCES: the response is dropped (no rsp_valid) and err_sticky[0] is set.
  - No backpressure on responses; instances must always accept them.
- almfull: gates new grants only. A request already registered still issues the next cycle; this is within the CCI-P almfull slack.
- idle: registered; 1 when all cnt==0 and c0_tx_valid==0.
- err_sticky clears only on reset.

Decomposition:
- Shared package (pipearch_common):
  - INST_TAG_W=2 and MDATA_TAG_MSB=15.
  - Typedef t_inst_id (logic [1:0]).
  - Function len_lines(cl_len) returning 3-bit.
- One sub-module: rr_arbiter, generic N-way round-robin with ptr, req vector in, one-hot grant out and grant_valid. It is reused later by the c1 write arbiter.

Test Plan:
- Single request: NUM=2, inst1 requests cl_len=0, mdata=16'h3ABC -> next cycle c0_tx_valid=1, mdata=16'h7ABC, cnt1=1. Response with mdata 16'h7ABC -> rsp_valid=2'b10, rsp mdata 16'h3ABC, cnt1=0, idle=1.
- Fairness: both instances hold req_valid continuously for 8 cycles -> grants alternate 0,1,0,1...; 4 grants each.
- Credit limit: MAX=4, inst0 issues 4 single-line reads with no responses -> 5th is not granted while inst1 is still granted. One response to inst0 -> inst0 is granted the next cycle. A cl_len=3 request is held while cnt0=1.
- almfull: c0_tx_almfull=1 for 5 cycles with both requesting -> no req_ready; c0_tx_valid=0 from the 2nd cycle; grants resume the cycle almfull drops.
- Simultaneous grant and response to inst0 with cnt0=2 and cl_len=1 -> cnt0=3. Response with tag 3 when NUM=2 -> dropped, err_sticky=2'b01. Response to inst1 with cnt1=0 -> err_sticky[1]=1, cnt1 stays 0.
- Reset mid-operation with cnt0=3 and c0_tx_valid=1 -> outputs 0 immediately (asynchronous), counters 0, ptr 0; the first grant after release goes to instance 0.
